// File: rtl/vedicdivider_seq.sv
// vedicdivider_seq -- sequential restoring divider, one quotient bit per clock.
//
// Divides an unsigned DATA_WIDTH-bit dividend by an unsigned DATA_WIDTH/2-bit
// divisor, producing a DATA_WIDTH-bit quotient and DATA_WIDTH/2-bit remainder.
// Valid/ready handshake on both the operand side and the result side.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   inValid       operands present on inData_A / inData_B
//   outReady      divider idle and able to accept operands
//   inData_A      dividend (DATA_WIDTH bits)
//   inData_B      divisor  (DATA_WIDTH/2 bits)
//   outValid      result valid, held until inReady
//   inReady       consumer takes the result
//   outData_Q     quotient  (DATA_WIDTH bits)
//   outData_R     remainder (DATA_WIDTH/2 bits)
//   outDivZero    divisor was zero (valid with outValid)
//
// Optional feature: define VEDICDIV_DIVZERO_EN to short-circuit a zero divisor
// (result after one CALC cycle, outDivZero=1). Without it a zero divisor runs
// the normal loop, which naturally yields Q=all ones, R=dividend low half.

module vedicdivider_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inValid,
    output logic                    outReady,
    input  logic [DATA_WIDTH-1:0]   inData_A,
    input  logic [DATA_WIDTH/2-1:0] inData_B,
    output logic                    outValid,
    input  logic                    inReady,
    output logic [DATA_WIDTH-1:0]   outData_Q,
    output logic [DATA_WIDTH/2-1:0] outData_R,
    output logic                    outDivZero
);
    localparam int DW = DATA_WIDTH;
    localparam int HW = DATA_WIDTH / 2;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state, state_n;
    logic [DW-1:0] dq;      // dividend bits shift out the top, quotient bits in the bottom
    logic [HW-1:0] dvs;     // captured divisor
    logic [HW-1:0] prt;     // stored partial remainder (always < divisor between steps)
    logic [CW-1:0] cnt;     // steps remaining

    logic          load, step, fin;
    logic [HW:0]   rem_sh;  // working partial remainder, one bit wider than divisor
    logic          ge;
    logic [HW-1:0] rem_nx;
    logic [DW-1:0] q_nx;

`ifdef VEDICDIV_DIVZERO_EN
    logic          zskip;
`endif

    // One restoring step: bring in the next dividend bit, trial-subtract.
    // With a zero divisor every step "subtracts" 0, so the top bit of rem_sh
    // is simply dropped and the low half ends up holding the last dividend bits.
    always_comb begin
        rem_sh = {prt, dq[DW-1]};
        ge     = (rem_sh >= {1'b0, dvs});
        rem_nx = ge ? HW'(rem_sh - {1'b0, dvs}) : rem_sh[HW-1:0];
        q_nx   = {dq[DW-2:0], ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        outReady = 1'b0;
        outValid = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        fin      = 1'b0;
`ifdef VEDICDIV_DIVZERO_EN
        zskip    = 1'b0;
`endif
        case (state)
            IDLE: begin
                outReady = 1'b1;
                if (inValid) begin
                    load    = 1'b1;
                    state_n = CALC;
                end
            end
            CALC: begin
`ifdef VEDICDIV_DIVZERO_EN
                if (dvs == '0) begin
                    zskip   = 1'b1;
                    state_n = DONE;
                end else
`endif
                begin
                    step = 1'b1;
                    if (cnt == CW'(1)) begin
                        fin     = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                outValid = 1'b1;
                // release here; IDLE is only reached next cycle, so no same-edge accept
                if (inReady) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq        <= '0;
            dvs       <= '0;
            prt       <= '0;
            cnt       <= '0;
            outData_Q <= '0;
            outData_R <= '0;
        end else begin
            if (load) begin
                dq  <= inData_A;
                dvs <= inData_B;
                prt <= '0;
                cnt <= CW'(DW);
            end
            if (step) begin
                dq  <= q_nx;
                prt <= rem_nx;
                cnt <= cnt - CW'(1);
            end
            if (fin) begin
                outData_Q <= q_nx;
                outData_R <= rem_nx;
            end
`ifdef VEDICDIV_DIVZERO_EN
            if (zskip) begin
                outData_Q <= '1;
                outData_R <= dq[HW-1:0];  // dq still holds the untouched dividend
            end
`endif
        end
    end

`ifdef VEDICDIV_DIVZERO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        outDivZero <= 1'b0;
        else if (zskip) outDivZero <= 1'b1;
        else if (fin)   outDivZero <= 1'b0;
    end
`else
    assign outDivZero = 1'b0;
`endif

endmodule
